// File: rtl/led_mode_controller.sv
// rtl/led_mode_controller.sv - switch-driven LED pattern controller with debounce and stepped patterns
module led_mode_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STEP_CYCLES     = 25000000
) (
    input  logic       SYSTEMCLOCK,
    input  logic       RESET,
    input  logic [3:0] gpio_switch,
    output logic [3:0] gpio_led,
    output logic [1:0] mode,
    output logic       step_strobe
);

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_STATIC = 2'd1,
        S_SHIFT  = 2'd2,
        S_COUNT  = 2'd3
    } state_t;

    localparam logic [23:0] DB_LAST   = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [27:0] STEP_LAST = 28'(STEP_CYCLES - 1);

    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [3:0]  r_deb;
    logic [23:0] r_db_cnt [0:3];

    state_t      r_state;
    state_t      w_next_state;
    logic [27:0] r_timer;
    logic [3:0]  r_pattern;
    logic        r_step_d1;

    logic [3:0]  r_led;
    logic [1:0]  r_mode;
    logic        r_strobe;

    logic [3:0]  w_led_src;
    logic [3:0]  w_stepped;
    logic        w_run;
    logic        w_wrap;
    logic        w_enter;

    always_ff @(posedge SYSTEMCLOCK) begin
        if (RESET) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= gpio_switch;
            r_sync2 <= r_sync1;
        end
    end

    // The counter only advances while the synced bit disagrees with the accepted value,
    // so any return to agreement discards partial progress.
    always_ff @(posedge SYSTEMCLOCK) begin
        if (RESET) begin
            r_deb <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_db_cnt[i] <= 24'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_db_cnt[i] <= 24'd0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_deb[i]    <= r_sync2[i];
                    r_db_cnt[i] <= 24'd0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 24'd1;
                end
            end
        end
    end

    always_ff @(posedge SYSTEMCLOCK) begin
        if (RESET) begin
            r_state <= S_OFF;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = state_t'(r_deb[1:0]);
    end

    always_comb begin
        w_led_src = 4'b0000;
        w_stepped = r_pattern;
        w_run     = 1'b0;
        case (r_state)
            S_OFF:    w_led_src = 4'b0000;
            S_STATIC: w_led_src = r_deb;
            S_SHIFT: begin
                w_led_src = r_pattern;
                w_run     = ~r_deb[2];
                w_stepped = r_deb[3] ? {r_pattern[0], r_pattern[3:1]}
                                     : {r_pattern[2:0], r_pattern[3]};
            end
            S_COUNT: begin
                w_led_src = r_pattern;
                w_run     = ~r_deb[2];
                w_stepped = r_deb[3] ? (r_pattern - 4'd1) : (r_pattern + 4'd1);
            end
            default: w_led_src = 4'b0000;
        endcase
    end

    assign w_enter = (w_next_state != r_state);
    assign w_wrap  = w_run && (r_timer == STEP_LAST);

    // State entry takes priority over a coinciding step so the fresh pattern is never stepped.
    always_ff @(posedge SYSTEMCLOCK) begin
        if (RESET) begin
            r_timer   <= 28'd0;
            r_pattern <= 4'b0000;
            r_step_d1 <= 1'b0;
        end else begin
            r_step_d1 <= 1'b0;
            if (w_enter) begin
                r_timer   <= 28'd0;
                r_pattern <= (w_next_state == S_SHIFT) ? 4'b0001 : 4'b0000;
            end else if (w_wrap) begin
                r_timer   <= 28'd0;
                r_pattern <= w_stepped;
                r_step_d1 <= 1'b1;
            end else if (w_run) begin
                r_timer   <= r_timer + 28'd1;
            end
        end
    end

    // Strobe is delayed one extra stage so it lines up with the registered LED drive.
    always_ff @(posedge SYSTEMCLOCK) begin
        if (RESET) begin
            r_led    <= 4'b0000;
            r_mode   <= 2'd0;
            r_strobe <= 1'b0;
        end else begin
            r_led    <= w_led_src;
            r_mode   <= r_state;
            r_strobe <= r_step_d1;
        end
    end

    assign gpio_led    = r_led;
    assign mode        = r_mode;
    assign step_strobe = r_strobe;

endmodule

// File: tb/tb_led_mode_controller.sv
// tb/tb_led_mode_controller.sv - directed self-checking bench for led_mode_controller
module tb_led_mode_controller;

    logic       SYSTEMCLOCK = 1'b0;
    logic       RESET;
    logic [3:0] gpio_switch;
    logic [3:0] gpio_led;
    logic [1:0] mode;
    logic       step_strobe;

    int n_cmp = 0;
    int n_bad = 0;

    led_mode_controller #(
        .DEBOUNCE_CYCLES(4),
        .STEP_CYCLES    (8)
    ) dut (
        .SYSTEMCLOCK(SYSTEMCLOCK),
        .RESET      (RESET),
        .gpio_switch(gpio_switch),
        .gpio_led   (gpio_led),
        .mode       (mode),
        .step_strobe(step_strobe)
    );

    always #5 SYSTEMCLOCK = ~SYSTEMCLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge SYSTEMCLOCK);
        #1;
    endtask

    // Seven quiet cycles, then the step lands with its strobe on the eighth.
    task automatic step_check(input logic [3:0] exp, input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (step_strobe) n++;
        end
        check({tag, "_quiet"}, n, 0);
        tick();
        check({tag, "_led"}, {28'd0, gpio_led}, {28'd0, exp});
        check({tag, "_stb"}, {31'd0, step_strobe}, 32'd1);
    endtask

    initial begin
        int         n;
        logic [3:0] seen;

        RESET       = 1'b1;
        gpio_switch = 4'h0;
        for (int i = 0; i < 3; i++) tick();
        check("rst_led", {28'd0, gpio_led}, 32'd0);
        check("rst_mode", {30'd0, mode}, 32'd0);
        check("rst_stb", {31'd0, step_strobe}, 32'd0);

        RESET = 1'b0;
        tick();
        check("post_rst_led", {28'd0, gpio_led}, 32'd0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (step_strobe) n++;
        end
        check("off_strobes", n, 0);
        check("off_led", {28'd0, gpio_led}, 32'd0);
        check("off_mode", {30'd0, mode}, 32'd0);

        // STATIC: 2 sync + 4 debounce + 1 state + 1 output register = 8 cycles
        gpio_switch = 4'h1;
        for (int i = 0; i < 7; i++) tick();
        check("static_early_mode", {30'd0, mode}, 32'd0);
        tick();
        check("static_mode", {30'd0, mode}, 32'd1);
        check("static_led", {28'd0, gpio_led}, 32'h1);

        gpio_switch = 4'h3;
        for (int i = 0; i < 3; i++) tick();
        gpio_switch = 4'h1;
        seen = 4'h1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gpio_led != 4'h1 && seen == 4'h1) seen = gpio_led;
        end
        check("glitch_led", {28'd0, seen}, 32'h1);
        check("glitch_mode", {30'd0, mode}, 32'd1);

        gpio_switch = 4'h2;
        for (int i = 0; i < 7; i++) tick();
        check("shift_early_mode", {30'd0, mode}, 32'd1);
        tick();
        check("shift_mode", {30'd0, mode}, 32'd2);
        check("shift_led0", {28'd0, gpio_led}, 32'h1);
        step_check(4'b0010, "shl1");
        step_check(4'b0100, "shl2");
        step_check(4'b1000, "shl3");
        step_check(4'b0001, "shl4");

        // Entry here coincides with a SHIFT wrap; entry must win with no strobe
        gpio_switch = 4'hB;
        for (int i = 0; i < 8; i++) tick();
        check("cnt_mode", {30'd0, mode}, 32'd3);
        check("cnt_led0", {28'd0, gpio_led}, 32'h0);
        check("cnt_entry_stb", {31'd0, step_strobe}, 32'd0);
        step_check(4'hF, "dn1");
        step_check(4'hE, "dn2");

        gpio_switch = 4'hF;
        n = 0;
        seen = 4'hE;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (step_strobe) n++;
            if (gpio_led != 4'hE && seen == 4'hE) seen = gpio_led;
        end
        check("pause_strobes", n, 0);
        check("pause_led", {28'd0, seen}, 32'hE);

        // Timer froze at its last count, so the step follows right after resume
        gpio_switch = 4'hB;
        for (int i = 0; i < 7; i++) tick();
        check("resume_hold_led", {28'd0, gpio_led}, 32'hE);
        tick();
        check("resume_led", {28'd0, gpio_led}, 32'hD);
        check("resume_stb", {31'd0, step_strobe}, 32'd1);

        gpio_switch = 4'h2;
        for (int i = 0; i < 8; i++) tick();
        check("shift2_led0", {28'd0, gpio_led}, 32'h1);
        step_check(4'b0010, "sh2a");
        step_check(4'b0100, "sh2b");
        gpio_switch = 4'h3;
        n = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (step_strobe) n++;
        end
        check("coin_quiet", n, 0);
        check("coin_pre_led", {28'd0, gpio_led}, 32'h4);
        tick();
        check("coin_led", {28'd0, gpio_led}, 32'h0);
        check("coin_stb", {31'd0, step_strobe}, 32'd0);
        check("coin_mode", {30'd0, mode}, 32'd3);
        step_check(4'h1, "up1");
        step_check(4'h2, "up2");
        step_check(4'h3, "up3");
        step_check(4'h4, "up4");
        step_check(4'h5, "up5");

        RESET = 1'b1;
        tick();
        check("midrst_led", {28'd0, gpio_led}, 32'd0);
        check("midrst_mode", {30'd0, mode}, 32'd0);
        check("midrst_stb", {31'd0, step_strobe}, 32'd0);
        RESET = 1'b0;
        tick();
        check("rel_mode", {30'd0, mode}, 32'd0);
        check("rel_led", {28'd0, gpio_led}, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check("reacq_early_mode", {30'd0, mode}, 32'd0);
        tick();
        check("reacq_mode", {30'd0, mode}, 32'd3);
        check("reacq_led", {28'd0, gpio_led}, 32'h0);
        step_check(4'h1, "reacq_up");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
